dtcm_banked: RTL and testbench

Banked, dual-port data tightly-coupled memory; successor of the single-port DTCM. Storage is split into 2**BW word-interleaved banks so the LSU port (A) and the DMA/debug port (B) proceed in parallel when they hit different banks. Each port has a valid/ready request channel and a valid/ready response channel with one-cycle read latency. It sits in the backend beside the LSU, replacing the single-port DTCM.

---
 rtl/dtcm_banked.sv | 172 +++++++++++++++++
 tb/tb_dtcm_banked.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dtcm_banked.sv
// Banked dual-port data TCM: 2**BW word-interleaved banks, per-port valid/ready request and response channels.
// Define DTCM_BANKED_FAIR_EN to promote port B after MAX_STALL consecutive conflict losses; otherwise A always wins.
module dtcm_banked #(
    parameter int DW        = 128,
    parameter int AW        = 14,
    parameter int BW        = 1,
    parameter int MAX_STALL = 4
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            a_req_valid,
    output logic            a_req_ready,
    input  logic [AW-1:0]   a_addr,
    input  logic            a_wen,
    input  logic [DW-1:0]   a_wdata,
    input  logic [DW/8-1:0] a_wmask,
    output logic            a_rsp_valid,
    input  logic            a_rsp_ready,
    output logic [DW-1:0]   a_rsp_rdata,
    input  logic            b_req_valid,
    output logic            b_req_ready,
    input  logic [AW-1:0]   b_addr,
    input  logic            b_wen,
    input  logic [DW-1:0]   b_wdata,
    input  logic [DW/8-1:0] b_wmask,
    output logic            b_rsp_valid,
    input  logic            b_rsp_ready,
    output logic [DW-1:0]   b_rsp_rdata
);
    localparam int NB    = 2**BW;
    localparam int RW    = AW - BW;
    localparam int DEPTH = 2**RW;
    localparam int MW    = DW / 8;
    localparam int SW    = $clog2(MAX_STALL + 1);

    // Index 0 is port A, index 1 is port B.
    logic            req_valid [2];
    logic            req_ready [2];
    logic [AW-1:0]   addr      [2];
    logic            wen       [2];
    logic [DW-1:0]   wdata     [2];
    logic [MW-1:0]   wmask     [2];
    logic            rsp_ready [2];
    logic            rsp_valid [2];
    logic [DW-1:0]   rsp_rdata [2];
    logic [BW-1:0]   bank      [2];
    logic            slot_free [2];
    logic            acc       [2];
    logic [DW-1:0]   bank_rd   [NB];
    logic            conflict;
    logic            b_pri;

    assign req_valid[0] = a_req_valid;
    assign req_valid[1] = b_req_valid;
    assign addr[0]      = a_addr;
    assign addr[1]      = b_addr;
    assign wen[0]       = a_wen;
    assign wen[1]       = b_wen;
    assign wdata[0]     = a_wdata;
    assign wdata[1]     = b_wdata;
    assign wmask[0]     = a_wmask;
    assign wmask[1]     = b_wmask;
    assign rsp_ready[0] = a_rsp_ready;
    assign rsp_ready[1] = b_rsp_ready;

    assign a_req_ready  = req_ready[0];
    assign b_req_ready  = req_ready[1];
    assign a_rsp_valid  = rsp_valid[0];
    assign b_rsp_valid  = rsp_valid[1];
    assign a_rsp_rdata  = rsp_rdata[0];
    assign b_rsp_rdata  = rsp_rdata[1];

    // A port only competes for a bank once its own response slot can take the result.
    assign conflict = req_valid[0] & slot_free[0] & req_valid[1] & slot_free[1]
                    & (bank[0] == bank[1]);
    assign req_ready[0] = slot_free[0] & ~(conflict & b_pri);
    assign req_ready[1] = slot_free[1] & ~(conflict & ~b_pri);

`ifdef DTCM_BANKED_FAIR_EN
    logic [SW-1:0] stall_cnt_reg;

    assign b_pri = (stall_cnt_reg == SW'(MAX_STALL));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            stall_cnt_reg <= '0;
        end else if (acc[1]) begin
            stall_cnt_reg <= '0;
        end else if (conflict && !b_pri) begin
            stall_cnt_reg <= stall_cnt_reg + SW'(1);
        end
    end
`else
    // MAX_STALL >= 1, so this is a constant 0: A wins every conflict.
    assign b_pri = (MAX_STALL < 1) && (SW == 0);
`endif

    genvar gi;

    for (gi = 0; gi < NB; gi++) begin : g_bank
        logic [DW-1:0] mem [DEPTH];
        logic [DW-1:0] rd_reg;
        logic          hit_a;
        logic          hit_b;
        logic [RW-1:0] row;
        logic          row_wen;
        logic [DW-1:0] row_wdata;
        logic [MW-1:0] row_wmask;

        assign hit_a     = acc[0] & (bank[0] == BW'(gi));
        assign hit_b     = acc[1] & (bank[1] == BW'(gi));
        assign row       = hit_b ? addr[1][AW-1:BW] : addr[0][AW-1:BW];
        assign row_wen   = hit_b ? wen[1]   : wen[0];
        assign row_wdata = hit_b ? wdata[1] : wdata[0];
        assign row_wmask = hit_b ? wmask[1] : wmask[0];
        assign bank_rd[gi] = rd_reg;

        // Arbitration guarantees at most one port hits a bank per cycle.
        always_ff @(posedge CLK) begin
            if (hit_a || hit_b) begin
                if (row_wen) begin
                    for (int i = 0; i < MW; i++) begin
                        if (row_wmask[i]) begin
                            mem[row][8*i +: 8] <= row_wdata[8*i +: 8];
                        end
                    end
                end else begin
                    rd_reg <= mem[row];
                end
            end
        end
    end

    for (gi = 0; gi < 2; gi++) begin : g_port
        logic          rsp_valid_reg;
        logic          fresh_reg;
        logic [BW-1:0] sel_reg;
        logic [DW-1:0] hold_reg;

        assign bank[gi]      = addr[gi][BW-1:0];
        assign slot_free[gi] = ~rsp_valid_reg | rsp_ready[gi];
        assign acc[gi]       = req_valid[gi] & req_ready[gi];
        assign rsp_valid[gi] = rsp_valid_reg;
        // The bank read register is shared, so its value is copied into hold_reg one cycle
        // after a read, before the other port can overwrite it.
        assign rsp_rdata[gi] = fresh_reg ? bank_rd[sel_reg] : hold_reg;

        always_ff @(posedge CLK or negedge RSTn) begin
            if (!RSTn) begin
                rsp_valid_reg <= 1'b0;
                fresh_reg     <= 1'b0;
                sel_reg       <= '0;
                hold_reg      <= '0;
            end else if (acc[gi]) begin
                rsp_valid_reg <= 1'b1;
                fresh_reg     <= ~wen[gi];
                sel_reg       <= bank[gi];
                if (wen[gi]) begin
                    hold_reg <= '0;
                end
            end else begin
                if (rsp_ready[gi]) begin
                    rsp_valid_reg <= 1'b0;
                end
                if (fresh_reg) begin
                    hold_reg  <= bank_rd[sel_reg];
                    fresh_reg <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_dtcm_banked.sv
// Randomized scoreboard bench for dtcm_banked: a reference memory plus the arbitration rules
// predict readiness and responses; a separate monitor checks responses against queued expectations.
module tb_dtcm_banked;
    localparam int DW        = 128;
    localparam int AW        = 14;
    localparam int BW        = 1;
    localparam int MW        = DW / 8;
    localparam int MAX_STALL = 4;
`ifdef DTCM_BANKED_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    typedef struct {
        logic          v;
        logic [AW-1:0] addr;
        logic          wen;
        logic [DW-1:0] wd;
        logic [MW-1:0] wm;
        logic          rr;
    } req_t;

    logic            CLK = 1'b0;
    logic            RSTn = 1'b0;
    logic            a_req_valid = 1'b0, b_req_valid = 1'b0;
    logic            a_req_ready, b_req_ready;
    logic [AW-1:0]   a_addr = '0, b_addr = '0;
    logic            a_wen = 1'b0, b_wen = 1'b0;
    logic [DW-1:0]   a_wdata = '0, b_wdata = '0;
    logic [MW-1:0]   a_wmask = '0, b_wmask = '0;
    logic            a_rsp_valid, b_rsp_valid;
    logic            a_rsp_ready = 1'b0, b_rsp_ready = 1'b0;
    logic [DW-1:0]   a_rsp_rdata, b_rsp_rdata;

    dtcm_banked #(.DW(DW), .AW(AW), .BW(BW), .MAX_STALL(MAX_STALL)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_addr(a_addr), .a_wen(a_wen),
        .a_wdata(a_wdata), .a_wmask(a_wmask), .a_rsp_valid(a_rsp_valid),
        .a_rsp_ready(a_rsp_ready), .a_rsp_rdata(a_rsp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_addr(b_addr), .b_wen(b_wen),
        .b_wdata(b_wdata), .b_wmask(b_wmask), .b_rsp_valid(b_rsp_valid),
        .b_rsp_ready(b_rsp_ready), .b_rsp_rdata(b_rsp_rdata)
    );

    always #5 CLK = ~CLK;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] ref_mem [2**AW];
    logic [DW-1:0] exp_q_a [$];
    logic [DW-1:0] exp_q_b [$];
    int            pend_a = 0, pend_b = 0;
    int            losses = 0;
    bit            dut_acc_b = 1'b0;
    req_t          na, nb;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [AW-1:0] pool_addr(input int k);
        return (k < 40) ? AW'(k) : AW'(16382 + (k - 40));
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                            input logic [MW-1:0] wm);
        logic [DW-1:0] r = old;
        for (int i = 0; i < MW; i++) if (wm[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic req_t idle_req();
        req_t r;
        r.v = 1'b0; r.addr = '0; r.wen = 1'b0; r.wd = '0; r.wm = '0; r.rr = 1'b1;
        return r;
    endfunction

    function automatic req_t mk(input logic [AW-1:0] ad, input logic w, input logic [DW-1:0] d,
                                input logic [MW-1:0] m, input logic rr);
        req_t r;
        r.v = 1'b1; r.addr = ad; r.wen = w; r.wd = d; r.wm = m; r.rr = rr;
        return r;
    endfunction

    // One clock cycle: drive na/nb, predict readiness from the arbitration rules, update the model.
    task automatic step();
        bit free_a, free_b, conf, bpri, ra, rb;
        @(negedge CLK);
        a_req_valid = na.v; a_addr = na.addr; a_wen = na.wen; a_wdata = na.wd; a_wmask = na.wm;
        a_rsp_ready = na.rr;
        b_req_valid = nb.v; b_addr = nb.addr; b_wen = nb.wen; b_wdata = nb.wd; b_wmask = nb.wm;
        b_rsp_ready = nb.rr;
        #2;
        free_a = (pend_a == 0) || na.rr;
        free_b = (pend_b == 0) || nb.rr;
        conf   = na.v && free_a && nb.v && free_b && (na.addr[BW-1:0] == nb.addr[BW-1:0]);
        bpri   = FAIR && (losses == MAX_STALL);
        ra     = free_a && !(conf && bpri);
        rb     = free_b && !(conf && !bpri);
        check("a_req_ready", DW'(a_req_ready), DW'(ra));
        check("b_req_ready", DW'(b_req_ready), DW'(rb));
        dut_acc_b = b_req_valid && b_req_ready;
        if (na.v && ra) exp_q_a.push_back(na.wen ? '0 : ref_mem[na.addr]);
        if (nb.v && rb) exp_q_b.push_back(nb.wen ? '0 : ref_mem[nb.addr]);
        if (na.v && ra && na.wen) ref_mem[na.addr] = merge(ref_mem[na.addr], na.wd, na.wm);
        if (nb.v && rb && nb.wen) ref_mem[nb.addr] = merge(ref_mem[nb.addr], nb.wd, nb.wm);
        pend_a = (na.v && ra) ? 1 : (na.rr ? 0 : pend_a);
        pend_b = (nb.v && rb) ? 1 : (nb.rr ? 0 : pend_b);
        if (nb.v && rb) losses = 0;
        else if (conf && !bpri && losses < MAX_STALL) losses++;
    endtask

    // Monitor: a response must be presented exactly while an expectation is queued.
    always @(negedge CLK) begin
        #1;
        if (RSTn) begin
            check("a_rsp_valid", DW'(a_rsp_valid), DW'(exp_q_a.size() != 0));
            if (a_rsp_valid && exp_q_a.size() != 0) begin
                check("a_rsp_rdata", a_rsp_rdata, exp_q_a[0]);
                if (a_rsp_ready) void'(exp_q_a.pop_front());
            end
            check("b_rsp_valid", DW'(b_rsp_valid), DW'(exp_q_b.size() != 0));
            if (b_rsp_valid && exp_q_b.size() != 0) begin
                check("b_rsp_rdata", b_rsp_rdata, exp_q_b[0]);
                if (b_rsp_ready) void'(exp_q_b.pop_front());
            end
        end
    end

    task automatic do_reset();
        @(negedge CLK);
        a_req_valid = 1'b0; b_req_valid = 1'b0; a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
        #3;
        RSTn = 1'b0;
        #1;
        check("rst_a_rsp_valid", DW'(a_rsp_valid), '0);
        check("rst_b_rsp_valid", DW'(b_rsp_valid), '0);
        check("rst_a_rsp_rdata", a_rsp_rdata, '0);
        check("rst_b_rsp_rdata", b_rsp_rdata, '0);
        exp_q_a.delete(); exp_q_b.delete();
        pend_a = 0; pend_b = 0; losses = 0;
        @(negedge CLK);
        #3;
        RSTn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int first_b;
        logic [DW-1:0] d;
        na = idle_req(); nb = idle_req();
        do_reset();

        // Preload every address the random phase may read.
        for (int k = 0; k < 42; k++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            na = mk(pool_addr(k), 1'b1, d, '1, 1'b1); nb = idle_req();
            step();
        end

        // Byte-masked write: byte0 from the second write, the rest from the first.
        na = mk(AW'('h10), 1'b1, {MW{8'hAA}}, '1, 1'b1); step();
        na = mk(AW'('h10), 1'b1, {MW{8'h55}}, MW'(1), 1'b1); step();
        na = mk(AW'('h10), 1'b0, '0, '0, 1'b1); step();
        na = idle_req(); step();

        // Different banks proceed in parallel.
        na = mk(AW'('h20), 1'b0, '0, '0, 1'b1); nb = mk(AW'('h21), 1'b0, '0, '0, 1'b1); step();
        na = idle_req(); nb = idle_req(); step();

        // Continuous bank-0 conflict: B wins only through the fairness promotion.
        first_b = -1;
        na = mk(AW'('h00), 1'b0, '0, '0, 1'b1); nb = mk(AW'('h02), 1'b0, '0, '0, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            step();
            if (dut_acc_b && first_b < 0) first_b = c;
        end
        check("starve_first_b_accept", DW'(first_b), FAIR ? DW'(5) : DW'(-1));
        na = idle_req(); nb = idle_req(); step(); step();

        // Response held while consumer stalls, then consume and accept on the same edge.
        na = mk(AW'('h05), 1'b0, '0, '0, 1'b1); step();
        na = mk(AW'('h07), 1'b0, '0, '0, 1'b0); step(); step(); step();
        na = mk(AW'('h07), 1'b0, '0, '0, 1'b1); step();
        na = idle_req(); step();

        // Back-to-back write then read of the same address on B.
        d = {$urandom, $urandom, $urandom, $urandom};
        nb = mk(AW'('h0B), 1'b1, d, '1, 1'b1); step();
        nb = mk(AW'('h0B), 1'b0, '0, '0, 1'b1); step();
        nb = idle_req(); step();

        // Random traffic over the preloaded pool.
        for (int c = 0; c < 500; c++) begin
            na = mk(pool_addr($urandom_range(0, 41)), 1'($urandom), {$urandom, $urandom, $urandom, $urandom},
                    ($urandom_range(0, 7) == 0) ? '0 : MW'($urandom), $urandom_range(0, 3) != 0);
            nb = mk(pool_addr($urandom_range(0, 41)), 1'($urandom), {$urandom, $urandom, $urandom, $urandom},
                    ($urandom_range(0, 7) == 0) ? '0 : MW'($urandom), $urandom_range(0, 3) != 0);
            na.v = ($urandom_range(0, 3) != 0);
            nb.v = ($urandom_range(0, 3) != 0);
            step();
        end

        // Reset with both responses pending; memory must survive.
        na = mk(AW'('h03), 1'b0, '0, '0, 1'b1); nb = mk(AW'('h04), 1'b0, '0, '0, 1'b1); step();
        na = idle_req(); nb = idle_req(); na.rr = 1'b0; nb.rr = 1'b0; step();
        do_reset();
        for (int k = 0; k < 42; k += 2) begin
            na = mk(pool_addr(k), 1'b0, '0, '0, 1'b1);
            nb = mk(pool_addr(k + 1), 1'b0, '0, '0, 1'b1);
            step();
        end
        na = idle_req(); nb = idle_req();
        for (int c = 0; c < 4; c++) step();
        check("drain_a_queue_empty", DW'(exp_q_a.size()), '0);
        check("drain_b_queue_empty", DW'(exp_q_b.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
